// File: rtl/cache_valid_ctrl.sv
// Valid-bit manager for one cache set array: maps fill/invalidate/lookup onto a
// 2W/1R valid RAM and clears every line with a sweep after reset or flush.

module cache_valid_ram #(
  parameter int WIDTH  = 1,
  parameter int DEEPTH = 8
) (
  input  logic              clk,
  input  logic              wa_en,
  input  logic [DEEPTH-1:0] wa_addr,
  input  logic [WIDTH-1:0]  wa_data,
  input  logic              wb_en,
  input  logic [DEEPTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              rd_en,
  input  logic [DEEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [2**DEEPTH];
  logic [WIDTH-1:0] rd_fwd;

  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wb_en) mem[wb_addr] <= wb_data;
    if (wa_en) mem[wa_addr] <= wa_data;
  end

  // Same-cycle writes are forwarded so a read sees the value being written.
  always_comb begin
    rd_fwd = mem[rd_addr];
    if (wa_en && (wa_addr == rd_addr))      rd_fwd = wa_data;
    else if (wb_en && (wb_addr == rd_addr)) rd_fwd = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= rd_fwd;
  end
endmodule

module cache_valid_ctrl #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_en,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_ack,
  output logic             lk_valid,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  output logic             fill_ready,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done
);
  localparam int STAGES = 1;
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] addr;
  } wr_req_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_d, flush_done_q;
  wr_req_t          wa, wb;
  logic             rd_data;
  logic [STAGES:0]  vld_pipe;
  logic [STAGES:0]  zero_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SWEEP;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wa      = '{en: 1'b0, addr: fill_idx};
    wb      = '{en: 1'b0, addr: inv_idx};
    unique case (state_q)
      ST_SWEEP: begin
        // Sweep owns port B; requests other than lookups are dropped.
        wb    = '{en: 1'b1, addr: cnt_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        wa.en = fill_en;
        wb.en = inv_en;
        cnt_d = '0;
        if (flush_req) state_d = ST_SWEEP;
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  assign vld_pipe[0]  = lk_en;
  assign zero_pipe[0] = lk_en && (state_q == ST_SWEEP);

  // Lookups taken during a sweep report invalid whatever the RAM holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1]  <= '0;
      zero_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
      zero_pipe[STAGES:1] <= zero_pipe[STAGES-1:0];
    end
  end

  cache_valid_ram #(
    .WIDTH  (1),
    .DEEPTH (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wa_en   (wa.en),
    .wa_addr (wa.addr),
    .wa_data (1'b1),
    .wb_en   (wb.en),
    .wb_addr (wb.addr),
    .wb_data (1'b0),
    .rd_en   (lk_en),
    .rd_addr (lk_idx),
    .rd_data (rd_data)
  );

  assign lk_ack     = vld_pipe[STAGES];
  assign lk_valid   = vld_pipe[STAGES] && !zero_pipe[STAGES] && rd_data;
  assign busy       = (state_q == ST_SWEEP);
  assign fill_ready = (state_q == ST_IDLE);
  assign flush_done = flush_done_q;
endmodule
